// File: rtl/pwm_multich_pkg.sv
// Shared types and default widths for the multichannel PWM.
// Imported by pwm_multich and pwm_deadtime_ch.
package pwm_multich_pkg;

  typedef enum logic [1:0] {
    CNT_UP     = 2'd0,
    CNT_DOWN   = 2'd1,
    CNT_UPDOWN = 2'd2,
    CNT_HOLD   = 2'd3
  } pwm_count_t;

  typedef enum logic [1:0] {
    LD_ZERO   = 2'd0,
    LD_PERIOD = 2'd1,
    LD_BOTH   = 2'd2,
    LD_IMM    = 2'd3
  } pwm_load_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DT_W  = 10;
  localparam int DEF_PRE_W = 8;
  localparam int DEF_INT_W = 8;

endpackage

// File: rtl/pwm_multich_deadtime.sv
// One channel of dead-time insertion and output polarity.
// PWM_FAULT_EN adds the trip input that mutes the outputs.
module pwm_deadtime_ch
  import pwm_multich_pkg::*;
#(
  parameter int DT_W = DEF_DT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            raw,
`ifdef PWM_FAULT_EN
  input  logic            trip,
`endif
  input  logic [DT_W-1:0] dtime_a,
  input  logic [DT_W-1:0] dtime_b,
  input  logic            logic_a,
  input  logic            logic_b,
  output logic            out_a,
  output logic            out_b
);

  localparam logic [DT_W-1:0] ONE = DT_W'(1);
  localparam logic [DT_W-1:0] MAX = '1;

  logic            raw_q;
  logic [DT_W-1:0] cnt;
  logic [DT_W-1:0] age;
  logic            flip;
  logic            a_on;
  logic            b_on;
  logic            mute;

`ifdef PWM_FAULT_EN
  logic blk;
`endif

  // edge detect and time since last raw edge
  always_comb begin
    flip = raw ^ raw_q;
    age  = flip ? '0 : cnt;
    a_on = raw & (age >= dtime_a);
    b_on = ~raw & (age >= dtime_b);
`ifdef PWM_FAULT_EN
    mute = trip | (blk & ~flip);
`else
    mute = 1'b0;
`endif
  end

  // delay counter and registered gate outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= 1'b0;
      cnt   <= '0;
      out_a <= 1'b0;
      out_b <= 1'b0;
    end else if (!en) begin
      raw_q <= 1'b0;
      cnt   <= '0;
      out_a <= ~logic_a;
      out_b <= ~logic_b;
    end else begin
      raw_q <= raw;
      if (flip)
        cnt <= ONE;
      else if (cnt != MAX)
        cnt <= cnt + ONE;
      if (mute) begin
        out_a <= ~logic_a;
        out_b <= ~logic_b;
      end else begin
        out_a <= a_on ~^ logic_a;
        out_b <= b_on ~^ logic_b;
      end
    end
  end

`ifdef PWM_FAULT_EN
  // hold outputs off after a trip until raw moves
  always_ff @(posedge clk) begin
    if (reset)
      blk <= 1'b0;
    else if (!en)
      blk <= trip;
    else
      blk <= trip | (blk & ~flip);
  end
`endif

endmodule

// File: rtl/pwm_multich.sv
// N-channel PWM with shared carrier, shadowed period/compare and
// interrupt decimator. PWM_FAULT_EN adds the fault trip latch.
module pwm_multich
  import pwm_multich_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DT_W  = DEF_DT_W,
  parameter int PRE_W = DEF_PRE_W,
  parameter int INT_W = DEF_INT_W
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef PWM_FAULT_EN
  input  logic                  fault,
  input  logic                  fault_clr,
  output logic                  tripped,
`endif
  input  logic                  en,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] compare,
  input  logic [1:0]            count_mode,
  input  logic [1:0]            load_mode,
  input  logic [PRE_W-1:0]      prescale,
  input  logic [DT_W-1:0]       dtime_a,
  input  logic [DT_W-1:0]       dtime_b,
  input  logic                  logic_a,
  input  logic                  logic_b,
  input  logic                  int_en,
  input  logic [INT_W-1:0]      event_count,
  output logic [N_CH-1:0]       pwmout_a,
  output logic [N_CH-1:0]       pwmout_b,
  output logic [CNT_W-1:0]      carrier,
  output logic                  interrupt
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [PRE_W-1:0] P_ONE = PRE_W'(1);
  localparam logic [INT_W-1:0] I_ONE = INT_W'(1);

  pwm_count_t mode;
  pwm_load_t  lmode;

  logic [PRE_W-1:0]            psc;
  logic                        tick;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_n;
  logic                        dir_up;
  logic                        dir_n;
  logic [CNT_W-1:0]            per_act;
  logic [N_CH-1:0][CNT_W-1:0]  cmp_act;
  logic                        zero_evt;
  logic                        per_evt;
  logic                        load;
  logic [N_CH-1:0]             raw;
  logic [INT_W-1:0]            icnt;

  assign mode    = pwm_count_t'(count_mode);
  assign lmode   = pwm_load_t'(load_mode);
  assign carrier = cnt_q;

  // tick strobe, carrier events and shadow load select
  always_comb begin
    tick     = en & (psc >= prescale);
    zero_evt = tick & (cnt_q == '0);
    per_evt  = tick & (cnt_q == per_act);
    load     = 1'b0;
    unique case (lmode)
      LD_ZERO:   load = zero_evt;
      LD_PERIOD: load = per_evt;
      LD_BOTH:   load = zero_evt | per_evt;
      LD_IMM:    load = 1'b1;
    endcase
  end

  // next carrier value and direction for the current mode
  always_comb begin
    cnt_n = cnt_q;
    dir_n = dir_up;
    unique case (mode)
      CNT_UP: begin
        if (cnt_q >= per_act)
          cnt_n = '0;
        else
          cnt_n = cnt_q + C_ONE;
      end
      CNT_DOWN: begin
        if (cnt_q == '0 || cnt_q > per_act)
          cnt_n = per_act;
        else
          cnt_n = cnt_q - C_ONE;
      end
      CNT_UPDOWN: begin
        if (dir_up) begin
          if (cnt_q < per_act) begin
            cnt_n = cnt_q + C_ONE;
          end else if (cnt_q != '0) begin
            cnt_n = cnt_q - C_ONE;
            dir_n = 1'b0;
          end
        end else begin
          if (cnt_q != '0) begin
            cnt_n = cnt_q - C_ONE;
          end else if (per_act != '0) begin
            cnt_n = C_ONE;
            dir_n = 1'b1;
          end
        end
      end
      CNT_HOLD: ;
    endcase
  end

  // prescaler and carrier
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      psc    <= '0;
      cnt_q  <= '0;
      dir_up <= 1'b1;
    end else begin
      psc <= tick ? '0 : psc + P_ONE;
      if (tick) begin
        cnt_q  <= cnt_n;
        dir_up <= dir_n;
      end
    end
  end

  // period and compare shadows, loaded together
  always_ff @(posedge clk) begin
    if (reset) begin
      per_act <= '0;
      cmp_act <= '0;
    end else if (!en || load) begin
      per_act <= period;
      cmp_act <= compare;
    end
  end

  // registered compare against the carrier
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      raw <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        raw[i] <= cnt_q < cmp_act[i];
    end
  end

  // zero-event decimator driving the interrupt pulse
  always_ff @(posedge clk) begin
    if (reset || !en || !int_en) begin
      icnt      <= '0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= 1'b0;
      if (zero_evt) begin
        if (icnt == event_count) begin
          interrupt <= 1'b1;
          icnt      <= '0;
        end else begin
          icnt <= icnt + I_ONE;
        end
      end
    end
  end

`ifdef PWM_FAULT_EN
  logic trip_n;

  assign trip_n = fault | (tripped & ~fault_clr);

  // trip latch, cleared only while fault is low
  always_ff @(posedge clk) begin
    if (reset)
      tripped <= 1'b0;
    else
      tripped <= trip_n;
  end
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_deadtime_ch #(
      .DT_W(DT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .raw     (raw[i]),
`ifdef PWM_FAULT_EN
      .trip    (trip_n),
`endif
      .dtime_a (dtime_a),
      .dtime_b (dtime_b),
      .logic_a (logic_a),
      .logic_b (logic_b),
      .out_a   (pwmout_a[i]),
      .out_b   (pwmout_b[i])
    );
  end

endmodule
